regmem_master: RTL and testbench

REGMEM_MASTER -- requirements
Module: regmem_master

---
 rtl/regmem_pkg.sv | 14 +
 rtl/regmem_timeout_ctr.sv | 27 ++
 rtl/regmem_master.sv | 102 ++++++++++
 tb/tb_regmem_master.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/regmem_pkg.sv
// Shared types and default widths for the register-memory master and responder.
package regmem_pkg;

  localparam int unsigned REGMEM_DATA_W = 16;
  localparam int unsigned REGMEM_ADDR_W = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2,
    RESP  = 2'd3
  } state_t;

endpackage

// File: rtl/regmem_timeout_ctr.sv
// Access timeout counter: counts cycles spent waiting for ack.
// expired pulses in the cycle whose tick would bring the count to TIMEOUT_CYCLES.
module regmem_timeout_ctr #(
  parameter int unsigned TIMEOUT_CYCLES = 15
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic tick,
  output logic expired
);

  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CntW-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      cnt_q <= '0;
    end else if (tick) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign expired = tick && (cnt_q == CntW'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/regmem_master.sv
// Register-memory master: turns cmd requests into sel/ack responder accesses.
// Define REGMEM_TIMEOUT_EN to abort accesses that see no ack within TIMEOUT_CYCLES.
module regmem_master
  import regmem_pkg::*;
#(
  parameter int unsigned DATA_W         = REGMEM_DATA_W,
  parameter int unsigned ADDR_W         = REGMEM_ADDR_W,
  parameter int unsigned TIMEOUT_CYCLES = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_wr,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              sel,
  output logic              wr,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] wdata,
  input  logic [DATA_W-1:0] rdata,
  input  logic              ack,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err
);

  state_t state_q, state_d;
  logic   busy, accept, timeout, done;

  assign busy      = (state_q == WRITE) || (state_q == READ);
  assign cmd_ready = (state_q == IDLE) && !reset;
  assign accept    = cmd_ready && cmd_valid;
  assign done      = busy && (ack || timeout);
  assign rsp_valid = (state_q == RESP);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:        if (cmd_valid) state_d = cmd_wr ? WRITE : READ;
      WRITE, READ: if (ack || timeout) state_d = RESP;
      RESP:        if (rsp_ready) state_d = IDLE;
      default:     state_d = IDLE;
    endcase
  end

  // Bus outputs are registered so sel/wr/addr/wdata are glitch-free for the responder.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      sel       <= 1'b0;
      wr        <= 1'b0;
      addr      <= '0;
      wdata     <= '0;
      rsp_rdata <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        sel   <= 1'b1;
        wr    <= cmd_wr;
        addr  <= cmd_addr;
        wdata <= cmd_wdata;
      end else if (done) begin
        sel       <= 1'b0;
        wr        <= 1'b0;
        rsp_rdata <= ((state_q == READ) && ack) ? rdata : '0;
      end
    end
  end

`ifdef REGMEM_TIMEOUT_EN
  logic err_q;

  regmem_timeout_ctr #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout_ctr (
    .clk    (clk),
    .reset  (reset),
    .clear  (accept),
    .tick   (busy && !ack),
    .expired(timeout)
  );

  // A same-cycle ack wins over expiry, so the error is simply "finished without ack".
  always_ff @(posedge clk) begin
    if (reset) begin
      err_q <= 1'b0;
    end else if (done) begin
      err_q <= !ack;
    end
  end

  assign rsp_err = err_q;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
  assign timeout            = 1'b0;
  assign rsp_err            = 1'b0;
`endif

endmodule

// File: tb/tb_regmem_master.sv
// Self-checking bench for regmem_master against a behavioural responder/memory model.
module tb_regmem_master;

  localparam int DW = 16;
  localparam int AW = 2;
  localparam int TO = 15;

  logic          clk = 1'b0;
  logic          reset;
  logic          cmd_valid, cmd_ready, cmd_wr;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic          sel, wr;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata, rdata;
  logic          ack, rsp_valid, rsp_ready, rsp_err;
  logic [DW-1:0] rsp_rdata;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] mem [4];

  regmem_master #(
    .DATA_W        (DW),
    .ADDR_W        (AW),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_wr   (cmd_wr),
    .cmd_addr (cmd_addr),
    .cmd_wdata(cmd_wdata),
    .sel      (sel),
    .wr       (wr),
    .addr     (addr),
    .wdata    (wdata),
    .rdata    (rdata),
    .ack      (ack),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata),
    .rsp_err  (rsp_err)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1);
  end

  // Issues one command, plays the responder (ack after ack_at sel cycles, -1 = never),
  // holds the response for `hold` cycles with rsp_ready low, then consumes it.
  task automatic run_txn(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                         input int ack_at, input logic [DW-1:0] rd, input int hold,
                         output int sel_cyc, output logic bus_ok,
                         output logic [DW-1:0] r_data, output logic r_err,
                         output logic held_ok);
    cmd_valid = 1'b1; cmd_wr = w; cmd_addr = a; cmd_wdata = d;
    @(posedge clk); #1;
    cmd_valid = 1'b0; cmd_wr = ~w; cmd_addr = AW'($urandom); cmd_wdata = DW'($urandom);
    sel_cyc = 0;
    bus_ok  = 1'b1;
    while (sel === 1'b1 && sel_cyc < 200) begin
      if (wr !== w || addr !== a || wdata !== d || rsp_valid !== 1'b0 || cmd_ready !== 1'b0)
        bus_ok = 1'b0;
      ack   = (sel_cyc == ack_at);
      rdata = ack ? rd : DW'($urandom);
      sel_cyc++;
      @(posedge clk); #1;
    end
    ack     = 1'b0;
    r_data  = rsp_rdata;
    r_err   = rsp_err;
    held_ok = (rsp_valid === 1'b1) && (sel === 1'b0) && (wr === 1'b0);
    for (int i = 0; i < hold; i++) begin
      ack   = 1'($urandom_range(0, 1));
      rdata = DW'($urandom);
      @(posedge clk); #1;
      if (rsp_valid !== 1'b1 || rsp_rdata !== r_data || rsp_err !== r_err || sel !== 1'b0 ||
          cmd_ready !== 1'b0 || addr !== a || wdata !== d)
        held_ok = 1'b0;
    end
    ack       = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) held_ok = 1'b0;
  endtask

  task automatic test_reset();
    logic [2*DW+AW+5-1:0] obs;
    reset = 1'b1; cmd_valid = 1'b0; cmd_wr = 1'b0; cmd_addr = '0; cmd_wdata = '0;
    ack = 1'b0; rdata = '0; rsp_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    obs = {sel, wr, addr, wdata, rsp_valid, rsp_rdata, rsp_err, cmd_ready};
    checks++;
    if (obs !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got %h required 0", obs);
    end
    reset = 1'b0;
    #1;
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_release_ready: got %b required 1", cmd_ready);
    end
  endtask

  task automatic test_write();
    int sc; logic ok, err, held; logic [DW-1:0] rd;
    run_txn(1'b1, 2'd2, 16'hA5A5, 0, DW'($urandom), 2, sc, ok, rd, err, held);
    checks++;
    if (sc !== 1 || ok !== 1'b1) begin
      errors++;
      $display("FAIL write_bus: got sel_cycles=%0d bus_ok=%b required 1/1", sc, ok);
    end
    checks++;
    if (rd !== 16'h0 || err !== 1'b0 || held !== 1'b1) begin
      errors++;
      $display("FAIL write_rsp: got rdata=%h err=%b held=%b required 0000/0/1", rd, err, held);
    end
  endtask

  task automatic test_read_delayed();
    int sc; logic ok, err, held; logic [DW-1:0] rd;
    run_txn(1'b0, 2'd3, DW'($urandom), 4, 16'h1234, 3, sc, ok, rd, err, held);
    checks++;
    if (sc !== 5 || ok !== 1'b1) begin
      errors++;
      $display("FAIL read_bus: got sel_cycles=%0d bus_ok=%b required 5/1", sc, ok);
    end
    checks++;
    if (rd !== 16'h1234 || err !== 1'b0 || held !== 1'b1) begin
      errors++;
      $display("FAIL read_rsp: got rdata=%h err=%b held=%b required 1234/0/1", rd, err, held);
    end
  endtask

  // Follows test_read_delayed, so the last response data is 16'h1234.
  task automatic test_ack_idle();
    for (int i = 0; i < 4; i++) begin
      ack = 1'b1; rdata = DW'($urandom);
      @(posedge clk); #1;
      checks++;
      if (sel !== 1'b0 || rsp_valid !== 1'b0 || cmd_ready !== 1'b1 || rsp_rdata !== 16'h1234)
      begin
        errors++;
        $display("FAIL ack_idle: got sel=%b rsp_valid=%b ready=%b rdata=%h required 0/0/1/1234",
                 sel, rsp_valid, cmd_ready, rsp_rdata);
      end
    end
    ack = 1'b0;
  endtask

  task automatic test_back_to_back();
    int busy_ready = 0;
    cmd_valid = 1'b1; cmd_wr = 1'b1; cmd_addr = 2'd1; cmd_wdata = 16'h1111;
    @(posedge clk); #1;
    cmd_wr = 1'b0; cmd_addr = 2'd2; cmd_wdata = 16'h2222;
    for (int i = 0; i < 3; i++) begin
      if (cmd_ready !== 1'b0) busy_ready++;
      ack       = (i == 1);
      rsp_ready = (i == 2);
      if (i < 2 && (addr !== 2'd1 || wdata !== 16'h1111 || wr !== 1'b1)) busy_ready++;
      @(posedge clk); #1;
    end
    ack = 1'b0; rsp_ready = 1'b0;
    checks++;
    if (busy_ready !== 0) begin
      errors++;
      $display("FAIL b2b_busy: got %0d bad cycles required 0", busy_ready);
    end
    checks++;
    if (cmd_ready !== 1'b1 || sel !== 1'b0) begin
      errors++;
      $display("FAIL b2b_idle: got ready=%b sel=%b required 1/0", cmd_ready, sel);
    end
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    checks++;
    if (sel !== 1'b1 || wr !== 1'b0 || addr !== 2'd2 || wdata !== 16'h2222) begin
      errors++;
      $display("FAIL b2b_second: got sel=%b wr=%b addr=%0d wdata=%h required 1/0/2/2222",
               sel, wr, addr, wdata);
    end
    ack = 1'b1; rdata = 16'h5A5A;
    @(posedge clk); #1;
    ack = 1'b0; rsp_ready = 1'b1;
    checks++;
    if (rsp_valid !== 1'b1 || rsp_rdata !== 16'h5A5A) begin
      errors++;
      $display("FAIL b2b_rsp: got valid=%b rdata=%h required 1/5a5a", rsp_valid, rsp_rdata);
    end
    @(posedge clk); #1;
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset_abort();
    cmd_valid = 1'b1; cmd_wr = 1'b0; cmd_addr = 2'd1; cmd_wdata = 16'h7777;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (sel !== 1'b1) begin
      errors++;
      $display("FAIL abort_pre_sel: got %b required 1", sel);
    end
    reset = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (sel !== 1'b0 || rsp_valid !== 1'b0 || cmd_ready !== 1'b0 || addr !== 2'd0) begin
      errors++;
      $display("FAIL abort_reset: got sel=%b valid=%b ready=%b addr=%0d required 0/0/0/0",
               sel, rsp_valid, cmd_ready, addr);
    end
    reset = 1'b0;
    #1;
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL abort_ready: got %b required 1", cmd_ready);
    end
    ack = 1'b1; rdata = 16'hDEAD;
    @(posedge clk); #1;
    ack = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (sel !== 1'b0 || rsp_valid !== 1'b0 || cmd_ready !== 1'b1 || rsp_rdata !== 16'h0) begin
      errors++;
      $display("FAIL abort_late_ack: got sel=%b valid=%b ready=%b rdata=%h required 0/0/1/0",
               sel, rsp_valid, cmd_ready, rsp_rdata);
    end
  endtask

  task automatic test_random();
    int sc, dly, hold; logic ok, err, held, w; logic [DW-1:0] rd, d, exp;
    logic [AW-1:0] a;
    for (int i = 0; i < 4; i++) mem[i] = DW'($urandom);
    for (int n = 0; n < 24; n++) begin
      w    = 1'($urandom_range(0, 1));
      a    = AW'($urandom);
      d    = DW'($urandom);
      dly  = $urandom_range(0, 6);
      hold = $urandom_range(0, 3);
      exp  = w ? 16'h0 : mem[a];
      run_txn(w, a, d, dly, mem[a], hold, sc, ok, rd, err, held);
      if (w) mem[a] = d;
      checks++;
      if (sc !== dly + 1 || ok !== 1'b1) begin
        errors++;
        $display("FAIL rand_bus[%0d]: got sel_cycles=%0d bus_ok=%b required %0d/1",
                 n, sc, ok, dly + 1);
      end
      checks++;
      if (rd !== exp || err !== 1'b0 || held !== 1'b1) begin
        errors++;
        $display("FAIL rand_rsp[%0d]: got rdata=%h err=%b held=%b required %h/0/1",
                 n, rd, err, held, exp);
      end
    end
  endtask

`ifdef REGMEM_TIMEOUT_EN
  task automatic test_timeout();
    int sc; logic ok, err, held; logic [DW-1:0] rd;
    run_txn(1'b0, 2'd2, DW'($urandom), -1, 16'hFFFF, 2, sc, ok, rd, err, held);
    checks++;
    if (sc !== TO || rd !== 16'h0 || err !== 1'b1 || ok !== 1'b1 || held !== 1'b1) begin
      errors++;
      $display("FAIL timeout_expire: got cyc=%0d rdata=%h err=%b ok=%b held=%b required %0d/0/1/1/1",
               sc, rd, err, ok, held, TO);
    end
    run_txn(1'b0, 2'd1, DW'($urandom), TO - 1, 16'hBEEF, 1, sc, ok, rd, err, held);
    checks++;
    if (sc !== TO || rd !== 16'hBEEF || err !== 1'b0 || ok !== 1'b1 || held !== 1'b1) begin
      errors++;
      $display("FAIL timeout_ack_wins: got cyc=%0d rdata=%h err=%b required %0d/beef/0",
               sc, rd, err, TO);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_write();
    test_read_delayed();
    test_ack_idle();
    test_back_to_back();
    test_reset_abort();
    test_random();
`ifdef REGMEM_TIMEOUT_EN
    test_timeout();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
